ram_fifo_ctrl: RTL
==================

Name: ram_fifo_ctrl

Overview:
- Pointer/flow-control stage that sits directly upstream of the 64x8 dual-address RAM.
- Turns the RAM into a synchronous FIFO: drives the RAM write port (data, address, enable) and read port (address, enable), and consumes the RAM's combinational read data.
- Exposes valid/ready push and pop interfaces to producer and consumer stages.
- Does not contain storage; the RAM is instantiated alongside it and shares Clk and Reset.

Parameters:
- DATA_W, 8, data width; must match the RAM word width.
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64.
- AF_LEVEL, 56, count at or above which almost_full asserts; legal range 1..2**ADDR_W.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous empty request; lower priority than Reset.
- push_valid  in  1  producer has data.
- push_ready  out  1  FIFO can accept; equals !full.
- push_data  in  DATA_W  write data.
- pop_valid  out  1  data available; equals !empty.
- pop_ready  in  1  consumer takes data.
- pop_data  out  DATA_W  head word; combinational from ram_read_data.
- count  out  ADDR_W+1  occupancy, 0..64.
- full  out  1  count == 64.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- ram_write_data  out  DATA_W  to RAM WriteData; equals push_data.
- ram_write_addr  out  ADDR_W  to RAM writeAddress; equals wr_ptr.
- ram_write_en  out  1  to RAM writeEn.
- ram_read_addr  out  ADDR_W  to RAM readAddress; equals rd_ptr.
- ram_read_en  out  1  to RAM readEn; equals !empty.
- ram_read_data  in  DATA_W  from RAM ReadData; high-Z when ram_read_en=0.

Behaviour:
- Reset: Clk, Reset synchronous active-high. On a Clk edge with Reset=1: wr_ptr=0, rd_ptr=0, count=0. After reset: empty=1, full=0, almost_full=0, push_ready=1, pop_valid=0, ram_read_en=0, ram_write_en=0.
- Reset mid-operation: in-flight push and pop are discarded. The RAM clears its contents on the same edge.
- ram_write_en during Reset or flush: forced 0 combinationally.
- push_fire = push_valid & push_ready & !Reset & !flush.
- pop_fire = pop_valid & pop_ready & !Reset & !flush.
- On push_fire: ram_write_en=1 that cycle; the RAM writes at the edge; wr_ptr increments.
- On pop_fire: rd_ptr increments.
- Read latency: zero. pop_data is valid in the same cycle pop_valid=1 and is read from RAM[rd_ptr]. The word written at edge N is visible on pop_data in cycle N+1.
- Pointers: ADDR_W bits; wrap from 63 to 0 with no special handling.
- count update:
  - +1 on push-only.
  - -1 on pop-only.
  - Unchanged on both or neither.
  - count is the sole source of full and empty; pointer equality is not used.
- Simultaneous push and pop:
  - At 0<count<64: both are accepted; count is unchanged.
  - When empty: pop_valid=0, so only the push proceeds; no fall-through bypass.
  - When full: push_ready=0 even if a pop occurs in the same cycle; no bypass.
- flush=1 (with Reset=0): pointers and count return to 0 at the edge. RAM contents are untouched and not cleared.
- Outputs full, empty, almost_full, push_ready, pop_valid decode the registered count; no combinational path from push_valid or pop_ready.
- Overflow (push_valid when full) and underflow (pop_ready when empty): ignored; state unchanged.

Optional Feature:
- Macro: RAM_FIFO_ERR_CNT_EN.
- When defined:
  - Adds output overflow_cnt (8 bits): increments on each cycle with push_valid & full.
  - Adds output underflow_cnt (8 bits): increments on each cycle with pop_ready & empty.
  - Both saturate at 255 and clear on Reset; flush does not clear them.
- When undefined: the ports and logic are absent.

Decomposition:
- Package fifo_pkg:
  - Constants DATA_W=8 and ADDR_W=6.
  - Derived DEPTH=64.
  - Typedefs for data word, address, and count (ADDR_W+1 bits).
- Sub-module fifo_ptr: ADDR_W-bit wrapping pointer with inc and clr inputs, synchronous Reset. Instantiated twice, for the write pointer and the read pointer.

Test Plan:
- Reset, then push 64 words 0x00..0x3F with pop_ready=0. Required: count 0->64; almost_full rises on the push that takes count to 56; full=1 and push_ready=0 after the 64th; a 65th push of 0xAA is ignored.
- Drain the full FIFO with pop_ready=1. Required: pop_data sequence 0x00..0x3F in order; empty=1 after the 64th pop; ram_read_en=0 and pop_valid=0 afterwards.
- Prefill 10 words, then push and pop every cycle for 100 cycles. Required: count stays 10; pointers wrap 63->0 with no lost or duplicated words; output equals input delayed by 10 words.
- Empty FIFO, push 0x5A with pop_ready=1 in the same cycle. Required: no pop that cycle; next cycle pop_valid=1 and pop_data=0x5A.
- With 20 words stored, assert flush for one cycle while push_valid=1. Required: count=0, empty=1, no RAM write that cycle. Then assert Reset mid-stream. Required: count=0, RAM readback all 0x00 after refill-free reads via the RAM port.
- With RAM_FIFO_ERR_CNT_EN defined: hold push_valid for 3 cycles while full and pop_ready for 2 cycles while empty. Required: overflow_cnt=3 and underflow_cnt=2; both clear to 0 on Reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
// Sizes match the 64x8 dual-address RAM this controller drives.
package fifo_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   count_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer valid-ready handshake bundle for the FIFO controller.
// The slave modport is the FIFO side, the master modport is the user side.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = fifo_pkg::DATA_W
);
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer with increment and synchronous clear.
// Wraps from the top address back to 0 by natural overflow.
module fifo_ptr #(
    parameter int ADDR_W = fifo_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);
    import fifo_pkg::*;

    // Pointer register: Reset and clear both return to address 0.
    always_ff @(posedge Clk) begin
        if (Reset || clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// Pointer/flow-control stage turning the external 64x8 RAM into a FIFO.
// Optional error counters are enabled by defining RAM_FIFO_ERR_CNT_EN.
module ram_fifo_ctrl #(
    parameter int DATA_W   = fifo_pkg::DATA_W,
    parameter int ADDR_W   = fifo_pkg::ADDR_W,
    parameter int AF_LEVEL = 56
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    ram_fifo_ctrl_if.slave    fifoIf,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [DATA_W-1:0] ram_write_data,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_read_addr,
    output logic              ram_read_en,
    input  logic [DATA_W-1:0] ram_read_data
`ifdef RAM_FIFO_ERR_CNT_EN
    ,
    output logic [7:0]        overflow_cnt,
    output logic [7:0]        underflow_cnt
`endif
);
    import fifo_pkg::*;

    localparam logic [ADDR_W:0] FullCnt = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AfCnt   = AF_LEVEL[ADDR_W:0];

    logic pushFire;
    logic popFire;

    // Status decodes come only from the registered count.
    assign full        = (count == FullCnt);
    assign empty       = (count == '0);
    assign almost_full = (count >= AfCnt);

    assign fifoIf.push_ready = !full;
    assign fifoIf.pop_valid  = !empty;
    assign fifoIf.pop_data   = ram_read_data;

    assign pushFire = fifoIf.push_valid && !full && !Reset && !flush;
    assign popFire  = fifoIf.pop_ready && !empty && !Reset && !flush;

    assign ram_write_data = fifoIf.push_data;
    assign ram_write_en   = pushFire;
    assign ram_read_en    = !empty;

    fifo_ptr #(.ADDR_W(ADDR_W)) wrPtr (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (flush),
        .inc   (pushFire),
        .ptr   (ram_write_addr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) rdPtr (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (flush),
        .inc   (popFire),
        .ptr   (ram_read_addr)
    );

    // Occupancy: push-only adds one, pop-only removes one.
    always_ff @(posedge Clk) begin
        if (Reset || flush)
            count <= '0;
        else if (pushFire && !popFire)
            count <= count + 1'b1;
        else if (popFire && !pushFire)
            count <= count - 1'b1;
    end

`ifdef RAM_FIFO_ERR_CNT_EN
    // Saturating counts of refused pushes and pops; flush keeps them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            overflow_cnt  <= '0;
            underflow_cnt <= '0;
        end else begin
            if (fifoIf.push_valid && full && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
            if (fifoIf.pop_ready && empty && underflow_cnt != 8'hFF)
                underflow_cnt <= underflow_cnt + 8'd1;
        end
    end
`endif
endmodule
